// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with a carry chain split into STAGES registered slices on a valid/ready stream.
// Define PIPELINED_ADDER_SAT_EN to clamp the signed result on overflow in the final stage.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] be_in;
  logic [STAGES-1:0] vld;

  // Inter-stage registers; entry STAGES-1 is unused because the last stage lands in the output registers.
  logic [WIDTH-1:0] aq   [STAGES];
  logic [WIDTH-1:0] beq  [STAGES];
  logic [WIDTH-1:0] accq [STAGES];
  logic             cq   [STAGES];

  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_be  [STAGES];
  logic [WIDTH-1:0] src_acc [STAGES];
  logic             src_c   [STAGES];
  logic             src_v   [STAGES];
  logic [WIDTH-1:0] nxt_acc [STAGES];
  logic             nxt_c   [STAGES];
  logic [SW:0]      slc     [STAGES];

  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_ovf;
  logic             fin_a_msb;
  logic             fin_be_msb;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign out_valid = vld[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign be_in     = sub ? ~b : b;

  always_comb begin
    src_a[0]   = a;
    src_be[0]  = be_in;
    src_acc[0] = '0;
    src_c[0]   = cin;
    src_v[0]   = in_valid && adv;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = aq[k-1];
      src_be[k]  = beq[k-1];
      src_acc[k] = accq[k-1];
      src_c[k]   = cq[k-1];
      src_v[k]   = vld[k-1];
    end
  end

  // Each stage resolves its own slice and splices it into the lower result slices it inherited.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slc[k] = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, src_be[k][k*SW +: SW]}
             + {{SW{1'b0}}, src_c[k]};
      nxt_acc[k] = src_acc[k];
      nxt_acc[k][k*SW +: SW] = slc[k][SW-1:0];
      nxt_c[k] = slc[k][SW];
    end
  end

  always_comb begin
    raw_sum    = nxt_acc[STAGES-1];
    fin_a_msb  = src_a[STAGES-1][WIDTH-1];
    fin_be_msb = src_be[STAGES-1][WIDTH-1];
    fin_ovf    = (fin_a_msb == fin_be_msb) && (raw_sum[WIDTH-1] != fin_a_msb);
`ifdef PIPELINED_ADDER_SAT_EN
    if (fin_ovf)
      fin_sum = fin_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      fin_sum = raw_sum;
`else
    fin_sum = raw_sum;
`endif
  end

  // Data only loads with a valid beat so the outputs keep the last result across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        aq[k]   <= '0;
        beq[k]  <= '0;
        accq[k] <= '0;
        cq[k]   <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++)
        vld[k] <= src_v[k];
      for (int k = 0; k < STAGES - 1; k++) begin
        if (src_v[k]) begin
          aq[k]   <= src_a[k];
          beq[k]  <= src_be[k];
          accq[k] <= nxt_acc[k];
          cq[k]   <= nxt_c[k];
        end
      end
      if (src_v[STAGES-1]) begin
        sum_q  <= fin_sum;
        cout_q <= nxt_c[STAGES-1];
        ovf_q  <= fin_ovf;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: arithmetic reference model plus directed hand-computed vectors.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cycle  = 0;
  int out_count = 0;
  int stall_cycles = 0;
  logic [WIDTH+1:0] exp_q [$];
  logic [WIDTH-1:0] obs_q [$];
  logic             prev_stall = 1'b0;
  logic [WIDTH+1:0] prev_out;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference: plain (WIDTH+1)-bit arithmetic, returns {ovf, cout, sum}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                             input logic cv, input logic sv);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   full;
    logic             o;
    logic [WIDTH-1:0] s;
    be   = sv ? ~bv : bv;
    full = {1'b0, av} + {1'b0, be} + {{WIDTH{1'b0}}, cv};
    s    = full[WIDTH-1:0];
    o    = (av[WIDTH-1] == be[WIDTH-1]) && (s[WIDTH-1] != av[WIDTH-1]);
`ifdef PIPELINED_ADDER_SAT_EN
    if (o) s = av[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return {o, full[WIDTH], s};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check_output("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check_output("stall_valid", out_valid, 1'b1);
        check_output("stall_hold", {ovf, cout, sum}, prev_out);
      end
      if (out_valid && !out_ready) stall_cycles++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_output("unexpected_out", sum, 64'hDEAD_BEEF);
        else check_output("model_out", {ovf, cout, sum}, exp_q.pop_front());
        obs_q.push_back(sum);
        out_count++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      prev_stall = out_valid && !out_ready;
      prev_out   = {ovf, cout, sum};
    end
  end

  task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic cv, input logic sv, output int acc);
    bit ok = 0;
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check_output("accept_timeout", 0, 1);
    @(posedge clk); #1;
    acc = cycle;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int acc, output logic [WIDTH-1:0] s, output logic c,
                             output logic o, output int lat);
    bit ok = 0;
    s = '0; c = 0; o = 0; lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        ok = 1; s = sum; c = cout; o = ovf; lat = cycle - acc;
        break;
      end
    end
    if (!ok) check_output("result_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, lat, base;
    logic [WIDTH-1:0] s;
    logic c, o;
    bit rnd_done;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #3;
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_sum", sum, 16'h0000);
    check_output("rst_cout_ovf", {cout, ovf}, 2'b00);
    check_output("rst_in_ready", in_ready, 1'b1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc);
    wait_result(acc, s, c, o, lat);
    check_output("ffff_plus_1", {o, c, s}, {1'b0, 1'b1, 16'h0000});
    check_output("latency", lat, STAGES - 1);

    apply_stimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc);
    wait_result(acc, s, c, o, lat);
`ifdef PIPELINED_ADDER_SAT_EN
    check_output("pos_ovf", {o, c, s}, {1'b1, 1'b0, 16'h7FFF});
`else
    check_output("pos_ovf", {o, c, s}, {1'b1, 1'b0, 16'h8000});
`endif

    apply_stimulus(16'h0005, 16'h0007, 1'b1, 1'b1, acc);
    wait_result(acc, s, c, o, lat);
    check_output("sub_5_7", {o, c, s}, {1'b0, 1'b0, 16'hFFFE});

    apply_stimulus(16'h8000, 16'h0001, 1'b1, 1'b1, acc);
    wait_result(acc, s, c, o, lat);
`ifdef PIPELINED_ADDER_SAT_EN
    check_output("neg_ovf", {o, c, s}, {1'b1, 1'b1, 16'h8000});
`else
    check_output("neg_ovf", {o, c, s}, {1'b1, 1'b1, 16'h7FFF});
`endif

    // Backpressure: eight back-to-back beats with out_ready low for three cycles.
    obs_q.delete();
    stall_cycles = 0;
    fork
      begin
        for (int i = 1; i <= 8; i++) apply_stimulus(WIDTH'(i), WIDTH'(i), 1'b0, 1'b0, acc);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check_output("bp_count", obs_q.size(), 8);
    check_output("bp_stalls", stall_cycles, 3);
    for (int i = 0; i < 8 && i < obs_q.size(); i++)
      check_output("bp_order", obs_q[i], 2 * (i + 1));

    // Reset with three beats still in flight.
    for (int i = 0; i < 3; i++) apply_stimulus(16'h0100, 16'h0001, 1'b0, 1'b0, acc);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", out_valid, 1'b0);
    check_output("mid_rst_data", {ovf, cout, sum}, 18'h0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    base = out_count;
    apply_stimulus(16'h1234, 16'h1111, 1'b0, 1'b0, acc);
    wait_result(acc, s, c, o, lat);
    check_output("post_rst_sum", s, 16'h2345);
    repeat (10) @(posedge clk);
    #1;
    check_output("post_rst_only_one", out_count - base, 1);

    // Random beats with random backpressure and input gaps.
    rnd_done = 0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          apply_stimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), acc);
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check_output("final_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
